multi_tone_phase_gen: RTL
=========================

MULTI_TONE_PHASE_GEN -- requirements
Module: multi_tone_phase_gen

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent phase channels, range 1..8.
REQ-002 Parameter PHASE_W, default 16: phase and increment width, fixed-point 1.2.13 when 16.
REQ-003 Parameter PI_POS, default 16'h6488: +pi in phase format.
REQ-004 Parameter PI_NEG, default 16'h9B78: -pi in phase format.
REQ-005 Parameter DECIM, default 5: output clock cycles per sample_tick, range 1..255.
REQ-006 clk  in  1  single clock, rising-edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 enable  in  1  high permits phase advance.
REQ-009 cfg_wr  in  1  one-cycle configuration write strobe.
REQ-010 cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of cfg_wr.
REQ-011 cfg_inc  in  PHASE_W  unsigned phase increment for cfg_ch.
REQ-012 cfg_clr  in  1  with cfg_wr, also clears that channel's phase accumulator to 0.
REQ-013 m_axis_phase_tvalid  out  1  phase word valid.
REQ-014 m_axis_phase_tready  in  1  downstream (CORDIC) accepts.
REQ-015 m_axis_phase_tdata  out  NUM_CH*PHASE_W  signed phases; channel k at bits [k*PHASE_W +: PHASE_W].
REQ-016 sample_tick  out  1  one-cycle strobe every DECIM cycles for downstream resampling.

Function
REQ-017 Per channel: signed accumulator acc[k] and increment register inc[k].
REQ-018 Advance condition: adv = enable && (!m_axis_phase_tvalid || m_axis_phase_tready).
REQ-019 On adv: tdata[k] <= acc[k] for all k, tvalid <= 1, acc[k] <= wrap(acc[k] + inc[k]).
REQ-020 On !adv with tready high: tvalid <= 0 (beat consumed, no new beat).
REQ-021 While tvalid && !tready: tdata and tvalid hold, acc[k] does not change.
REQ-022 wrap(s): s computed at PHASE_W+1 bits signed; if s > PI_POS then PI_NEG + (s - PI_POS), else s; result always within [PI_NEG, PI_POS].
REQ-023 cfg_inc > PI_POS is clamped to PI_POS on write.
REQ-024 cfg_wr loads inc[cfg_ch] at that edge; a same-cycle adv uses the old increment.
REQ-025 cfg_wr with cfg_clr: acc[cfg_ch] <= 0, overriding a same-cycle advance for that channel only; other channels advance normally.
REQ-026 cfg_ch >= NUM_CH: write ignored.
REQ-027 Latency: first beat after enable rises appears one cycle later, carrying the current acc values (0 after reset).
REQ-028 Decimation counter runs freely from reset, independent of enable and handshake; sample_tick high for one cycle when counter == DECIM-1, then counter wraps to 0; with DECIM=1 sample_tick is constantly high.
REQ-029 No combinational path from m_axis_phase_tready to m_axis_phase_tvalid or tdata.

Reset
REQ-030 rst asserts asynchronously: acc, inc, tdata all 0, tvalid 0, decimation counter 0, sample_tick 0.
REQ-031 rst mid-stream discards the pending beat; after release, behaviour restarts per REQ-027 with all increments 0.
REQ-032 First sample_tick is DECIM cycles after rst deasserts.

Verification
REQ-033 Reset: assert rst with enable=1 -> tvalid=0, tdata=0, sample_tick=0 immediately, without a clock edge.
REQ-034 Wrap: ch1 inc=3000, tready=1, enable=1 -> ch1 beats 0, 3000, ..., 24000, then -24472, then -21472.
REQ-035 Two-tone: ch0 inc=200, ch1 inc=3000 -> beat n: ch0 = 200n, ch1 per REQ-034; ch0 first wraps at n=129 to -25736+64 = -25672.
REQ-036 Backpressure: tready low for 3 cycles mid-stream -> tdata held, no phase skipped after tready returns.
REQ-037 Config corner cases: cfg_inc=30000 -> behaves as 25736; cfg_wr+cfg_clr on ch1 during streaming -> next-but-one ch1 beat is 0 while ch0 continues uninterrupted.
REQ-038 Decimation: DECIM=5 -> sample_tick high on cycles 5, 10, 15 after reset release, regardless of enable/tready.

Source files
------------

// File: rtl/multi_tone_phase_gen.sv
// Multi-channel phase accumulator feeding a CORDIC over a valid/ready stream.
// Every channel advances in lockstep when a beat can be issued. Each phase wraps
// so that it stays within [-pi, +pi]. A free-running decimation counter
// produces sample_tick.
module multi_tone_phase_gen #(
    parameter int unsigned         NUM_CH  = 2,
    parameter int unsigned         PHASE_W = 16,
    parameter logic [PHASE_W-1:0]  PI_POS  = 16'h6488,
    parameter logic [PHASE_W-1:0]  PI_NEG  = 16'h9B78,
    parameter int unsigned         DECIM   = 5,
    localparam int unsigned        CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        cfg_wr,
    input  logic [CH_W-1:0]             cfg_ch,
    input  logic [PHASE_W-1:0]          cfg_inc,
    input  logic                        cfg_clr,
    output logic                        m_axis_phase_tvalid,
    input  logic                        m_axis_phase_tready,
    output logic [NUM_CH*PHASE_W-1:0]   m_axis_phase_tdata,
    output logic                        sample_tick
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DECIM - 1);

    // acc + inc, folded back into [PI_NEG, PI_POS] by subtracting one full turn.
    // inc is clamped to PI_POS on write, so the sum can only overflow upward.
    function automatic logic signed [PHASE_W-1:0] wrap_add(
        input logic signed [PHASE_W-1:0] acc,
        input logic        [PHASE_W-1:0] inc
    );
        logic signed [PHASE_W:0] sum;
        logic signed [PHASE_W:0] pos;
        logic signed [PHASE_W:0] neg;
        logic signed [PHASE_W:0] res;
        sum = $signed({acc[PHASE_W-1], acc}) + $signed({1'b0, inc});
        pos = $signed({1'b0, PI_POS});
        neg = $signed({PI_NEG[PHASE_W-1], PI_NEG});
        if (sum > pos) begin
            res = neg + (sum - pos);
        end else begin
            res = sum;
        end
        return res[PHASE_W-1:0];
    endfunction

    logic signed [PHASE_W-1:0]  acc_q [NUM_CH];
    logic signed [PHASE_W-1:0]  acc_d [NUM_CH];
    logic        [PHASE_W-1:0]  inc_q [NUM_CH];
    logic        [PHASE_W-1:0]  inc_d [NUM_CH];
    logic [NUM_CH*PHASE_W-1:0]  tdata_q, tdata_d;
    logic                       tvalid_q, tvalid_d;
    logic [CNT_W-1:0]           dec_cnt_q, dec_cnt_d;
    logic                       tick_q, tick_d;

    logic                       adv;
    logic [PHASE_W-1:0]         inc_wr;
    logic [NUM_CH-1:0]          cfg_sel;

    // Advance when enabled and the output slot is empty or being drained.
    always_comb begin
        adv    = enable && (!tvalid_q || m_axis_phase_tready);
        inc_wr = (cfg_inc > PI_POS) ? PI_POS : cfg_inc;
        // Out-of-range channel numbers match no k and are thus ignored.
        for (int k = 0; k < NUM_CH; k++) begin
            cfg_sel[k] = cfg_wr && (cfg_ch == CH_W'(k));
        end
    end

    // Output beat register: load on advance, drop valid once consumed.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (adv) begin
            tvalid_d = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                tdata_d[k*PHASE_W +: PHASE_W] = acc_q[k];
            end
        end else if (m_axis_phase_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Per-channel accumulators and increments; a clear beats a same-cycle advance.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k] = acc_q[k];
            inc_d[k] = inc_q[k];
            if (adv) begin
                acc_d[k] = wrap_add(acc_q[k], inc_q[k]);
            end
            if (cfg_sel[k]) begin
                inc_d[k] = inc_wr;
                if (cfg_clr) begin
                    acc_d[k] = '0;
                end
            end
        end
    end

    // Decimation counter, independent of enable and handshake.
    always_comb begin
        tick_d    = (dec_cnt_q == CntLast);
        dec_cnt_d = (dec_cnt_q == CntLast) ? '0 : dec_cnt_q + 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= '0;
                inc_q[k] <= '0;
            end
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            dec_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= acc_d[k];
                inc_q[k] <= inc_d[k];
            end
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            dec_cnt_q <= dec_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign m_axis_phase_tvalid = tvalid_q;
    assign m_axis_phase_tdata  = tdata_q;
    assign sample_tick         = tick_q;

endmodule
